// File: rtl/sram_1rw_wmask_port_ctrl.sv
// Valid/ready request front-end for a 1rw write-masked SRAM macro with an in-order read response FIFO.
// Reads return 2 edges after acceptance; req_ready is credit-gated so a stalled consumer never drops data.

module sram_1rw_wmask_resp_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                         core_clk,
    input  logic                         arst_n,
    input  logic                         in_vld,
    input  logic [W-1:0]                 in_dat,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [W-1:0]                 out_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_vld) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= ptr_nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_nxt(rd_ptr);
            end
            if (in_vld && !pop) begin
                count <= count + 1'b1;
            end else if (!in_vld && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Upstream credits guarantee a slot for every push.
    always_ff @(posedge core_clk) begin
        if (arst_n) begin
            assert (!(in_vld && count == ($clog2(DEPTH+1))'(DEPTH)));
        end
    end
endmodule

module sram_1rw_wmask_port_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASK  = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASK-1:0]  req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic [NUM_WMASK-1:0]  wmask0,
    input  logic [DATA_WIDTH-1:0] dout0
);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic          run;
    logic          rd_tag0;
    logic          rd_tag1;
    logic          accept;
    logic [CW-1:0] fifo_count;

    // Reads in flight already own a FIFO slot, so the check uses state only.
    assign req_ready = run &&
        ((32'(fifo_count) + 32'(rd_tag0) + 32'(rd_tag1)) < 32'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            run     <= 1'b0;
            csb0    <= 1'b1;
            web0    <= 1'b1;
            addr0   <= '0;
            din0    <= '0;
            wmask0  <= '0;
            rd_tag0 <= 1'b0;
            rd_tag1 <= 1'b0;
        end else begin
            run     <= 1'b1;
            csb0    <= 1'b1;
            web0    <= 1'b1;
            rd_tag0 <= accept && !req_we;
            rd_tag1 <= rd_tag0;
            if (accept) begin
                if (!req_we) begin
                    csb0  <= 1'b0;
                    addr0 <= req_addr;
                end else if (req_wmask != '0) begin
                    csb0   <= 1'b0;
                    web0   <= 1'b0;
                    addr0  <= req_addr;
                    din0   <= req_wdata;
                    wmask0 <= req_wmask;
                end
            end
        end
    end

    sram_1rw_wmask_resp_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .core_clk (clk0),
        .arst_n   (rstb0),
        .in_vld   (rd_tag1),
        .in_dat   (dout0),
        .out_vld  (rsp_valid),
        .out_rdy  (rsp_ready),
        .out_dat  (rsp_rdata),
        .count    (fifo_count)
    );
endmodule

// File: doc/sram_1rw_wmask_port_ctrl.md
# sram_1rw_wmask_port_ctrl

Request front-end that sits directly upstream of a single-port (1rw) write-masked OpenRAM macro and drives its `csb0/web0/addr0/din0/wmask0` pins. It accepts read/write requests on a valid/ready interface, issues at most one SRAM access per cycle, captures `dout0` at the correct edge, and returns read data in order through a credit-protected response FIFO. Backpressure on the response side therefore never loses read data.

## Interface
- `DATA_WIDTH`, 2: SRAM word width.
- `ADDR_WIDTH`, 4: SRAM address width (16 words).
- `NUM_WMASK`, 2: write-mask bits; each bit covers `DATA_WIDTH/NUM_WMASK` data bits; must divide evenly.
- `RESP_DEPTH`, 4: response FIFO entries; minimum 2; 4 sustains one read per cycle.
- `clk0`  in  1  clock; all flops on rising edge.
- `rstb0`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted at an edge where valid and ready are both high.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wmask`  in  NUM_WMASK  write byte-enable; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes data at an edge where `rsp_valid` and `rsp_ready` are both high.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `csb0`  out  1  SRAM chip select, active-low.
- `web0`  out  1  SRAM write enable, active-low.
- `addr0`  out  ADDR_WIDTH  SRAM address.
- `din0`  out  DATA_WIDTH  SRAM write data.
- `wmask0`  out  NUM_WMASK  SRAM write mask.
- `dout0`  in  DATA_WIDTH  SRAM read data.

## Operation
- SRAM pins are registers. An accepted request at edge N loads them, the SRAM samples them at edge N+1, and `dout0` is valid during the cycle after edge N+1.
- Accepted read: `csb0=0`, `web0=1`, `addr0=req_addr` for exactly one cycle. A 2-deep read tag pipeline marks the cycle in which `dout0` is captured into the FIFO at edge N+2.
- Accepted write with a nonzero mask: `csb0=0`, `web0=0`, and `addr0/din0/wmask0` loaded for one cycle. No response is produced.
- Accepted write with `req_wmask==0`: it is consumed, but `csb0` stays 1 and no SRAM access is made.
- Idle cycle: `csb0=1` and `web0=1`. `addr0`, `din0` and `wmask0` hold their last values.
- Credits: `free = RESP_DEPTH - fifo_count - reads_in_flight`, where in-flight counts 0..2.
  - `req_ready = (free > 0)` for both reads and writes.
  - `req_ready` depends only on state, never combinationally on `req_*` or `rsp_ready`.
- Order: requests issue in acceptance order, so read-after-write to the same address returns the written data. Responses are strictly in order.
- Data is passed through unmodified. X bits from unwritten or masked-out bits propagate to `rsp_rdata`.
- FIFO:
  - Push and pop in the same edge is legal at any occupancy.
  - A push into a full FIFO is impossible by credit construction; assertion-checked.
  - `rsp_rdata` shows the head entry while `rsp_valid=1`.

## Timing
- Reset (`rstb0=0`, asynchronous): `csb0=1`, `web0=1`, `addr0=0`, `din0=0`, `wmask0=0`, `rsp_valid=0`, `rsp_rdata=0`, `req_ready=0`. FIFO, in-flight tags and counts are cleared.
- First edge after `rstb0` rises: `req_ready=1`.
- Read latency: accepted at edge N, then `rsp_valid=1` after edge N+2 if the FIFO was empty. Minimum 2 cycles.
- Throughput: one request per cycle while `free>0`. Writes also stall when credits are exhausted.
- Reset mid-operation: in-flight reads and queued responses are discarded. No response appears after reset release for pre-reset requests.
- Address wrap: none; addresses are used as-is, full range 0..2^ADDR_WIDTH-1.

## Test plan
- Reset: assert `rstb0=0` mid-cycle → all outputs take their reset values immediately. Release → `req_ready=1` after the first edge.
- Masked write then read: write addr 1, data 2'b10, mask 2'b10; then read addr 1 → `csb0` low one cycle each, `web0` low only for the write. `rsp_rdata=2'b1x` with `rsp_valid` rising 2 edges after read acceptance.
- Sequence:
  - Write C/2'b01/mask 01, then read 0 → 2'bxx.
  - Read C → 2'bx1.
  - Write 1/2'b01/mask 01, then read 1 → 2'b11.
  - Read 0 → 2'bxx.
  - All responses arrive in order.
- Backpressure: hold `rsp_ready=0` and offer 6 back-to-back reads → exactly 4 accepted, then `req_ready=0`. Raise `rsp_ready` → 4 responses in order, then the remaining 2 are accepted and returned.
- Zero-mask write: write addr 3, mask 2'b00 → accepted, `csb0` stays 1. A following read of addr 3 returns the prior contents.
- Reset mid-flight: accept reads at two consecutive edges, then pulse `rstb0` low → `rsp_valid=0` immediately and no responses after release.
